// File: rtl/conv_pkg.sv
// Dispatcher state type and instruction field positions for the conv layer sequencer.
package conv_pkg;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_t;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int ADDR_MSB = 27;
    localparam int ADDR_LSB = 12;
    localparam int LEN_MSB  = 11;
    localparam int LEN_LSB  = 0;
endpackage

// File: rtl/conv_top.svh
// Opcode encodings shared by the conv layer blocks and their instruction producers.
`ifndef CONV_TOP_SVH
`define CONV_TOP_SVH
`define OP_LF 4'h1
`define OP_LI 4'h2
`define OP_LS 4'h3
`define OP_DC 4'h4
`endif

// File: rtl/dispatch_watchdog.sv
// Cycle counter for one outstanding command; pulses timeout on the TIMEOUT-th enabled cycle.
module dispatch_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    assign timeout = en && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !timeout) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/inst_dispatch.sv
// Conv-layer instruction sequencer: pops instructions, issues them to the load or conv
// engine one at a time, tracks loaded operands and watchdogs each outstanding command.
`include "conv_top.svh"

module inst_dispatch
    import conv_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_r_en,
    input  logic             fifo_r_accept,
    input  logic [31:0]      fifo_inst,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic             ld_sel,
    output logic [15:0]      ld_addr,
    output logic [11:0]      ld_len,
    input  logic             ld_done,
    output logic             conv_valid,
    input  logic             conv_ready,
    output logic [15:0]      conv_addr,
    input  logic             conv_done,
    output logic [11:0]      cfg,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       dbg_state
);
    // Handshake: a command transfers on a rising edge where valid && ready. valid is held,
    // with a stable payload, until that edge; ready is ignored while valid is low.
    disp_state_t state;
    logic [31:0] inst_q;
    logic        flt_ok, img_ok;
    logic [3:0]  op;
    logic        is_ld, is_dc, is_ls, dc_ok, done_hit, wd_timeout;

    assign op = inst_q[OP_MSB:OP_LSB];

    always_comb begin
        is_ld      = (op == `OP_LF) || (op == `OP_LI);
        is_dc      = (op == `OP_DC);
        is_ls      = (op == `OP_LS);
        dc_ok      = flt_ok && img_ok;
        done_hit   = (is_ld && ld_done) || (is_dc && conv_done);
        fifo_r_en  = (state == FETCH);
        busy       = (state != FETCH);
        ld_valid   = (state == ISSUE) && is_ld;
        ld_sel     = (op == `OP_LI);
        ld_addr    = inst_q[ADDR_MSB:ADDR_LSB];
        ld_len     = inst_q[LEN_MSB:LEN_LSB];
        conv_valid = (state == ISSUE) && is_dc && dc_ok;
        conv_addr  = inst_q[ADDR_MSB:ADDR_LSB];
        dbg_state  = state;
    end

    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    dispatch_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            inst_q  <= '0;
            flt_ok  <= 1'b0;
            img_ok  <= 1'b0;
            cfg     <= '0;
            err     <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (fifo_r_accept) begin
                        inst_q <= fifo_inst;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_ld) begin
                        if (ld_ready) state <= WAIT;
                    end else if (is_dc && dc_ok) begin
                        if (conv_ready) state <= WAIT;
                    end else if (is_ls) begin
                        cfg     <= inst_q[LEN_MSB:LEN_LSB];
                        retired <= retired + CNT_W'(1);
                        state   <= FETCH;
                    end else begin
                        // Unknown opcode or DC without both operands loaded.
                        err   <= 1'b1;
                        state <= FETCH;
                    end
                end
                WAIT: begin
                    if (done_hit) begin
                        retired <= retired + CNT_W'(1);
                        if (op == `OP_LF) flt_ok <= 1'b1;
                        if (op == `OP_LI) img_ok <= 1'b1;
                        state <= FETCH;
                    end else if (wd_timeout) begin
                        err   <= 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch with an expected-command scoreboard on both engine ports.
module tb_inst_dispatch;
  localparam int TB_TIMEOUT = 32;
  localparam int CW = 16;
  localparam logic [3:0] OP_LF = 4'h1;
  localparam logic [3:0] OP_LI = 4'h2;
  localparam logic [3:0] OP_LS = 4'h3;
  localparam logic [3:0] OP_DC = 4'h4;

  logic          clk, rst;
  logic          fifo_r_en, fifo_r_accept;
  logic [31:0]   fifo_inst;
  logic          ld_valid, ld_ready, ld_sel, ld_done;
  logic [15:0]   ld_addr;
  logic [11:0]   ld_len;
  logic          conv_valid, conv_ready, conv_done;
  logic [15:0]   conv_addr;
  logic [11:0]   cfg;
  logic          busy, err;
  logic [CW-1:0] retired;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [28:0] ld_exp_q[$];
  logic [15:0] conv_exp_q[$];

  inst_dispatch #(.TIMEOUT(TB_TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .fifo_r_en(fifo_r_en), .fifo_r_accept(fifo_r_accept), .fifo_inst(fifo_inst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_len(ld_len), .ld_done(ld_done),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_addr(conv_addr),
    .conv_done(conv_done),
    .cfg(cfg), .busy(busy), .err(err), .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // scoreboard: any transfer on either engine port must match the oldest expected command
  always @(negedge clk) begin
    #1;
    if (!rst && ld_valid && ld_ready) begin
      if (ld_exp_q.size() == 0) check("ld_unexpected", 32'd1, 32'd0);
      else check("ld_cmd", {3'b0, ld_sel, ld_addr, ld_len}, {3'b0, ld_exp_q.pop_front()});
    end
    if (!rst && conv_valid && conv_ready) begin
      if (conv_exp_q.size() == 0) check("conv_unexpected", 32'd1, 32'd0);
      else check("conv_cmd", {16'b0, conv_addr}, {16'b0, conv_exp_q.pop_front()});
    end
  end

  // driver: present one instruction at the FIFO head and let the DUT pop it
  task automatic issue_inst(input logic [31:0] inst);
    int n;
    n = 0;
    while (!fifo_r_en && n < 200) begin
      tick();
      n++;
    end
    check("fifo_r_en_seen", {31'b0, fifo_r_en}, 32'd1);
    fifo_inst = inst;
    fifo_r_accept = 1'b1;
    tick();
    fifo_r_accept = 1'b0;
    fifo_inst = $urandom();
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [15:0] a, input logic [11:0] l);
    return {op, a, l};
  endfunction

  // load command: optional ready stall, then done pulse done_delay cycles after accept
  task automatic do_ld(input logic [31:0] inst, input int stall, input int done_delay);
    ld_exp_q.push_back({inst[31:28] == OP_LI, inst[27:0]});
    issue_inst(inst);
    repeat (stall) tick();
    ld_ready = 1'b1;
    tick();
    ld_ready = 1'b0;
    if (done_delay > 0) begin
      repeat (done_delay - 1) tick();
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
    end
  endtask

  task automatic do_dc(input logic [31:0] inst, input int done_delay);
    conv_exp_q.push_back(inst[27:12]);
    issue_inst(inst);
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    repeat (done_delay - 1) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  initial begin
    int k;
    logic [11:0] len;
    logic [15:0] addr;
    rst = 1'b1; fifo_r_accept = 1'b0; fifo_inst = '0;
    ld_ready = 1'b0; ld_done = 1'b0; conv_ready = 1'b0; conv_done = 1'b0;
    do_reset();

    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_retired", {16'b0, retired}, 32'd0);
    check("rst_cfg", {20'b0, cfg}, 32'd0);
    check("rst_valids", {30'b0, ld_valid, conv_valid}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // DC with no operands loaded: dropped with error; conv_ready high exposes a stray valid
    conv_ready = 1'b1;
    issue_inst(mk(OP_DC, 16'h0040, 12'h0));
    check("dc_guard_valid", {31'b0, conv_valid}, 32'd0);
    tick();
    conv_ready = 1'b0;
    check("dc_guard_err", {31'b0, err}, 32'd1);
    check("dc_guard_retired", {16'b0, retired}, 32'd0);
    check("dc_guard_fetch", {31'b0, fifo_r_en}, 32'd1);

    // LS retires in one cycle and updates cfg
    issue_inst(32'h3000_0ABC);
    check("ls_no_ld", {31'b0, ld_valid}, 32'd0);
    check("ls_no_conv", {31'b0, conv_valid}, 32'd0);
    tick();
    check("ls_cfg", {20'b0, cfg}, 32'h0ABC);
    check("ls_retired", {16'b0, retired}, 32'd1);
    check("ls_busy", {31'b0, busy}, 32'd0);

    // LF with a 5-cycle ready stall, done 3 cycles after accept
    ld_exp_q.push_back({1'b0, 16'h1234, 12'd9});
    issue_inst(mk(OP_LF, 16'h1234, 12'd9));
    for (int i = 0; i < 5; i++) begin
      check("lf_hold_valid", {31'b0, ld_valid}, 32'd1);
      check("lf_hold_addr", {16'b0, ld_addr}, 32'h1234);
      check("lf_hold_len", {20'b0, ld_len}, 32'd9);
      tick();
    end
    ld_ready = 1'b1;
    tick();
    ld_ready = 1'b0;
    check("lf_wait_state", {30'b0, dbg_state}, 32'd2);
    check("lf_valid_drop", {31'b0, ld_valid}, 32'd0);
    tick();
    tick();
    check("lf_busy_wait", {31'b0, busy}, 32'd1);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("lf_retired", {16'b0, retired}, 32'd2);
    check("lf_busy_done", {31'b0, busy}, 32'd0);

    // LF, LI (with a done on the accept edge that must not count), DC
    do_reset();
    do_ld(mk(OP_LF, 16'h0100, 12'd4), 0, 2);
    ld_exp_q.push_back({1'b1, 16'h0200, 12'd8});
    issue_inst(mk(OP_LI, 16'h0200, 12'd8));
    ld_ready = 1'b1;
    ld_done = 1'b1;
    tick();
    ld_ready = 1'b0;
    ld_done = 1'b0;
    check("li_early_done_busy", {31'b0, busy}, 32'd1);
    check("li_early_done_ret", {16'b0, retired}, 32'd1);
    tick();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("li_retired", {16'b0, retired}, 32'd2);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    check("stray_conv_done", {16'b0, retired}, 32'd2);
    do_dc(mk(OP_DC, 16'h0040, 12'h0), 4);
    check("dc_retired", {16'b0, retired}, 32'd3);
    check("dc_err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      addr = 16'($urandom_range(0, 16'hFFFF));
      len = 12'($urandom_range(1, 12'hFFF));
      do_ld(mk((i % 2) ? OP_LI : OP_LF, addr, len), $urandom_range(0, 3), $urandom_range(1, 5));
      do_dc(mk(OP_DC, addr ^ 16'h5A5A, 12'h0), $urandom_range(1, 5));
    end
    check("rand_retired", {16'b0, retired}, 32'd9);

    // watchdog on LI; image flag must stay clear so a following DC is refused
    do_reset();
    do_ld(mk(OP_LF, 16'h0010, 12'd2), 0, 1);
    ld_exp_q.push_back({1'b1, 16'h0020, 12'd3});
    issue_inst(mk(OP_LI, 16'h0020, 12'd3));
    ld_ready = 1'b1;
    tick();
    ld_ready = 1'b0;
    k = 0;
    while (!err && k < TB_TIMEOUT + 10) begin
      tick();
      k++;
    end
    check("wdog_cycles", k, TB_TIMEOUT);
    check("wdog_retired", {16'b0, retired}, 32'd1);
    check("wdog_busy", {31'b0, busy}, 32'd0);
    conv_ready = 1'b1;
    issue_inst(mk(OP_DC, 16'h0080, 12'h0));
    check("wdog_img_flag", {31'b0, conv_valid}, 32'd0);
    tick();
    conv_ready = 1'b0;
    check("wdog_dc_dropped", {16'b0, retired}, 32'd1);

    // unknown opcode
    do_reset();
    issue_inst(mk(4'hF, 16'hFFFF, 12'hFFF));
    tick();
    check("badop_err", {31'b0, err}, 32'd1);
    check("badop_retired", {16'b0, retired}, 32'd0);

    // reset in WAIT mid-load; a late done is ignored
    do_reset();
    issue_inst(32'h3000_0123);
    tick();
    ld_exp_q.push_back({1'b0, 16'h0777, 12'd5});
    issue_inst(mk(OP_LF, 16'h0777, 12'd5));
    ld_ready = 1'b1;
    tick();
    ld_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_cfg", {20'b0, cfg}, 32'd0);
    check("midrst_retired", {16'b0, retired}, 32'd0);
    check("midrst_valids", {30'b0, ld_valid, conv_valid}, 32'd0);
    check("midrst_fetch", {31'b0, fifo_r_en}, 32'd1);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("late_done_retired", {16'b0, retired}, 32'd0);
    check("late_done_busy", {31'b0, busy}, 32'd0);

    tick();
    check("ld_q_left", ld_exp_q.size(), 32'd0);
    check("conv_q_left", conv_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
